clarvi_part_sequencer: RTL and testbench

- Parametrised successor to the fixed 8-part decode counter. It accepts one 32-bit RISC-V instruction per handshake and issues it as NUM_PARTS = XLEN/SLICE_W micro-beats.
- Each beat carries its part index, in ascending, descending or half-descending order, and the matching SLICE_W-bit slice of the fully expanded immediate.
- It sits between fetch and the sliced decode/forwarding logic. It replaces the hard-wired instr_part counter and the per-part immediate case tables.

---
 rtl/clarvi_part_sequencer_pkg.sv | 52 +++++
 rtl/clarvi_part_sequencer_imm_expand.sv | 40 ++++
 rtl/clarvi_part_sequencer.sv | 131 +++++++++++++
 tb/tb_clarvi_part_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clarvi_part_sequencer_pkg.sv
// Shared types and RISC-V opcode constants for the part sequencer and its
// immediate expander.
package clarvi_part_sequencer_pkg;

   typedef enum logic [1:0] {
      ASCEND       = 2'd0,
      DESCEND      = 2'd1,
      DESCEND_HALF = 2'd2,
      ORDER_RSVD   = 2'd3
   } part_order_t;

   typedef enum logic [2:0] {
      FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHAMT, FMT_ZIMM, FMT_NONE
   } imm_fmt_t;

   typedef enum logic {IDLE, ISSUE} seq_state_t;

   localparam logic [6:0] OPC_LOAD      = 7'h03;
   localparam logic [6:0] OPC_OP_IMM    = 7'h13;
   localparam logic [6:0] OPC_AUIPC     = 7'h17;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
   localparam logic [6:0] OPC_STORE     = 7'h23;
   localparam logic [6:0] OPC_LUI       = 7'h37;
   localparam logic [6:0] OPC_BRANCH    = 7'h63;
   localparam logic [6:0] OPC_JALR      = 7'h67;
   localparam logic [6:0] OPC_JAL       = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM    = 7'h73;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   function automatic imm_fmt_t imm_fmt(input logic [31:0] instr);
      imm_fmt_t   fmt;
      logic [2:0] f3;
      f3  = instr[14:12];
      fmt = FMT_NONE;
      case (instr[6:0])
         OPC_LOAD, OPC_JALR:     fmt = FMT_I;
         OPC_OP_IMM, OPC_OP_IMM_32:
            fmt = (f3 == F3_SLL || f3 == F3_SR) ? FMT_SHAMT : FMT_I;
         OPC_STORE:              fmt = FMT_S;
         OPC_BRANCH:             fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:     fmt = FMT_U;
         OPC_JAL:                fmt = FMT_J;
         // Only the CSR*I forms carry a zimm field.
         OPC_SYSTEM:             fmt = f3[2] ? FMT_ZIMM : FMT_NONE;
         default:                fmt = FMT_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/clarvi_part_sequencer_imm_expand.sv
// Combinational immediate expansion of one instruction to XLEN bits; shift
// amounts are replicated into every SLICE_W part instead of extended.
module clarvi_part_sequencer_imm_expand
   import clarvi_part_sequencer_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int SLICE_W = 8
) (
   input  logic [31:0]     instr_i,
   output logic            imm_used_o,
   output logic [XLEN-1:0] imm_full_o
);

   localparam int NUM_PARTS = XLEN / SLICE_W;
   localparam int SH_W      = (SLICE_W < 6) ? SLICE_W : 6;

   imm_fmt_t            fmt;
   logic signed [31:0]  imm32;
   logic [SLICE_W-1:0]  sh_slice;

   always_comb begin
      fmt      = imm_fmt(instr_i);
      sh_slice = SLICE_W'(instr_i[20 +: SH_W]);
      imm32    = '0;
      case (fmt)
         FMT_I:    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         FMT_S:    imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         FMT_B:    imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
         FMT_U:    imm32 = {instr_i[31:12], 12'b0};
         FMT_J:    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
         FMT_ZIMM: imm32 = {27'b0, instr_i[19:15]};
         default:  imm32 = '0;
      endcase
      imm_full_o = (fmt == FMT_SHAMT) ? {NUM_PARTS{sh_slice}} : XLEN'(imm32);
      imm_used_o = (fmt != FMT_NONE);
   end

endmodule

// File: rtl/clarvi_part_sequencer.sv
// Issues one captured instruction as XLEN/SLICE_W beats with part index and
// immediate slice. Define CLARVI_SEQ_FLUSH_EN to add the flush input.
module clarvi_part_sequencer
   import clarvi_part_sequencer_pkg::*;
#(
   parameter  int XLEN      = 64,
   parameter  int SLICE_W   = 8,
   localparam int NUM_PARTS = XLEN / SLICE_W,
   localparam int PART_W    = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1
) (
   input  logic               clock,
   input  logic               reset,
`ifdef CLARVI_SEQ_FLUSH_EN
   input  logic               flush,
`endif
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [1:0]         in_order,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_instr,
   output logic [XLEN-1:0]    out_pc,
   output logic [PART_W-1:0]  out_part,
   output logic [PART_W-1:0]  out_seq,
   output logic               out_first,
   output logic               out_last,
   output logic [SLICE_W-1:0] out_imm,
   output logic               out_imm_used
);

   seq_state_t        state_q, state_d;
   logic [PART_W-1:0] seq_q, seq_d;
   part_order_t       order_q, order_d;
   logic [31:0]       instr_q, instr_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   imm_q, imm_d;
   logic              used_q, used_d;

   logic              flush_w;
   logic              imm_used_w;
   logic [XLEN-1:0]   imm_full_w;
   logic [PART_W-1:0] mask;
   logic              capture;

`ifdef CLARVI_SEQ_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   clarvi_part_sequencer_imm_expand #(.XLEN(XLEN), .SLICE_W(SLICE_W)) u_imm (
      .instr_i    (in_instr),
      .imm_used_o (imm_used_w),
      .imm_full_o (imm_full_w)
   );

   // XOR with NUM_PARTS-1 reverses the whole word; with parts-per-32-bits
   // minus one it reverses inside each half. Both collapse when XLEN=32.
   always_comb begin
      case (order_q)
         DESCEND:      mask = PART_W'(NUM_PARTS - 1);
         DESCEND_HALF: mask = PART_W'(32 / SLICE_W - 1);
         default:      mask = '0;
      endcase
   end

   assign out_valid    = (state_q == ISSUE);
   assign out_seq      = seq_q;
   assign out_first    = (seq_q == '0);
   assign out_last     = (seq_q == PART_W'(NUM_PARTS - 1));
   assign out_part     = seq_q ^ mask;
   assign out_imm      = imm_q[int'(out_part) * SLICE_W +: SLICE_W];
   assign out_imm_used = used_q;
   assign out_instr    = instr_q;
   assign out_pc       = pc_q;

   assign in_ready = !flush_w && ((state_q == IDLE) || (out_last && out_ready));
   assign capture  = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      order_d = order_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      used_d  = used_q;
      if (flush_w) begin
         state_d = IDLE;
         seq_d   = '0;
      end else if (capture) begin
         state_d = ISSUE;
         seq_d   = '0;
         order_d = part_order_t'(in_order);
         instr_d = in_instr;
         pc_d    = in_pc;
         imm_d   = imm_full_w;
         used_d  = imm_used_w;
      end else if (state_q == ISSUE && out_ready) begin
         if (out_last) begin
            state_d = IDLE;
            seq_d   = '0;
         end else begin
            seq_d = seq_q + PART_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         seq_q   <= '0;
         order_q <= ASCEND;
         instr_q <= '0;
         pc_q    <= '0;
         imm_q   <= '0;
         used_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         order_q <= order_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         used_q  <= used_d;
      end
   end

endmodule

// File: tb/tb_clarvi_part_sequencer.sv
// Bench for clarvi_part_sequencer (XLEN=64, SLICE_W=8): directed cases with
// literal expectations plus random traffic checked against a beat-queue model.
module tb_clarvi_part_sequencer;

   localparam int XLEN = 64;
   localparam int NP   = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, out_instr;
   logic [63:0] in_pc, out_pc;
   logic [1:0]  in_order;
   logic [2:0]  out_part, out_seq;
   logic        out_first, out_last, out_imm_used;
   logic [7:0]  out_imm;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      int          part;
      int          seq;
      logic [7:0]  imm;
      logic        used;
   } beat_t;

   beat_t q[$];

   clarvi_part_sequencer #(.XLEN(64), .SLICE_W(8)) dut (
      .clock(clock), .reset(reset),
`ifdef CLARVI_SEQ_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .in_order(in_order), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_part(out_part), .out_seq(out_seq), .out_first(out_first),
      .out_last(out_last), .out_imm(out_imm), .out_imm_used(out_imm_used)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Immediate straight from the ISA encoding tables, RV64.
   function automatic logic [63:0] ref_imm(input logic [31:0] i, output logic used);
      logic [63:0] v;
      v    = '0;
      used = 1'b1;
      case (i[6:0])
         7'h03, 7'h67: v = {{52{i[31]}}, i[31:20]};
         7'h13, 7'h1B:
            if (i[13:12] == 2'b01) v = {8{{2'b00, i[25:20]}}};
            else                   v = {{52{i[31]}}, i[31:20]};
         7'h23:        v = {{52{i[31]}}, i[31:25], i[11:7]};
         7'h63:        v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         7'h37, 7'h17: v = {{32{i[31]}}, i[31:12], 12'h000};
         7'h6F:        v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         7'h73:        if (i[14]) v = {59'd0, i[19:15]}; else used = 1'b0;
         default:      used = 1'b0;
      endcase
      return v;
   endfunction

   function automatic int part_of(input int ord, input int s);
      case (ord)
         1:       return NP - 1 - s;
         2:       return (s / 4) * 4 + 3 - (s % 4);
         default: return s;
      endcase
   endfunction

   task automatic push_instr(input logic [31:0] ins, input logic [63:0] pc, input int ord);
      logic [63:0] full;
      logic        u;
      beat_t       b;
      full = ref_imm(ins, u);
      for (int s = 0; s < NP; s++) begin
         b.instr = ins; b.pc = pc; b.seq = s; b.used = u;
         b.part  = part_of(ord, s);
         b.imm   = full[b.part*8 +: 8];
         q.push_back(b);
      end
   endtask

   // Compare process: outputs checked mid-cycle, model advanced at the edge.
   initial begin
      logic ev, eir, acc, cap, fl;
      logic [31:0] ci;
      logic [63:0] cp;
      int co;
      forever begin
         @(negedge clock);
         if (reset) q.delete();
         ev  = (q.size() != 0);
         eir = 1'b1;
         if (ev) eir = (q[0].seq == NP - 1) && out_ready;
         eir = eir && !flush;
         chk("out_valid", 64'(out_valid), 64'(ev));
         chk("in_ready", 64'(in_ready), 64'(eir));
         if (ev) begin
            chk("out_seq", 64'(out_seq), 64'(q[0].seq));
            chk("out_part", 64'(out_part), 64'(q[0].part));
            chk("out_imm", 64'(out_imm), 64'(q[0].imm));
            chk("out_imm_used", 64'(out_imm_used), 64'(q[0].used));
            chk("out_first", 64'(out_first), 64'(q[0].seq == 0));
            chk("out_last", 64'(out_last), 64'(q[0].seq == NP - 1));
            chk("out_instr", 64'(out_instr), 64'(q[0].instr));
            chk("out_pc", out_pc, q[0].pc);
         end
         fl  = flush && !reset;
         acc = ev && out_ready && !reset;
         cap = in_valid && eir && !reset;
         ci = in_instr; cp = in_pc; co = int'(in_order);
         @(posedge clock);
         if (fl) q.delete();
         else begin
            if (acc) void'(q.pop_front());
            if (cap) push_instr(ci, cp, co);
         end
      end
   end

   task automatic run_dir(input string nm, input logic [31:0] ins, input logic [1:0] ord,
                          input logic [23:0] ep, input logic [63:0] ei);
      logic [7:0][2:0] gp;
      logic [7:0][7:0] gi;
      logic [7:0]      gf, gl;
      int k;
      gp = '0; gi = '0; gf = '0; gl = '0; k = 0;
      out_ready = 1; in_valid = 1; in_instr = ins; in_order = ord;
      in_pc = {$urandom, $urandom};
      @(posedge clock); #1 in_valid = 0;
      for (int c = 0; c < 20 && k < NP; c++) begin
         @(negedge clock);
         if (out_valid && out_ready) begin
            gp[k] = out_part; gi[k] = out_imm; gf[k] = out_first; gl[k] = out_last;
            k++;
         end
      end
      chk({nm, "_beats"}, 64'(k), 64'(NP));
      chk({nm, "_parts"}, 64'(gp), 64'(ep));
      chk({nm, "_imm"}, gi, ei);
      chk({nm, "_first"}, 64'(gf), 64'h01);
      chk({nm, "_last"}, 64'(gl), 64'h80);
      @(posedge clock); #1;
   endtask

   initial begin
      logic        u;
      int          tf[2];
      int          nf, sent, cnt;
      logic        hs;
      logic [6:0]  opcs[12];
      logic [31:0] r;
      opcs = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
               7'h6F, 7'h73, 7'h33, 7'h0F};
      in_valid = 0; in_instr = '0; in_pc = '0; in_order = '0; out_ready = 1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_part", 64'(out_part), 0);
      chk("rst_out_imm", 64'(out_imm), 0);
      chk("rst_imm_used", 64'(out_imm_used), 0);
      reset = 0;
      chk("pin_lui", ref_imm(32'h123452B7, u), 64'h0000_0000_1234_5000);
      chk("pin_beq", ref_imm(32'hFE000EE3, u), 64'hFFFF_FFFF_FFFF_FFFC);
      @(posedge clock); #1;

      run_dir("addi", 32'hFFF00093, 2'd0, 24'o76543210, 64'hFFFF_FFFF_FFFF_FFFF);
      run_dir("lui", 32'h123452B7, 2'd0, 24'o76543210, 64'h0000_0000_1234_5000);
      run_dir("srliw_half", 32'h0030D09B, 2'd2, 24'o45670123, 64'h0303_0303_0303_0303);
      run_dir("srli_desc", 32'h0030D093, 2'd1, 24'o01234567, 64'h0303_0303_0303_0303);
      run_dir("beq_rsvd", 32'hFE000EE3, 2'd3, 24'o76543210, 64'hFFFF_FFFF_FFFF_FFFC);

      // Back-to-back: first beats exactly NP cycles apart.
      nf = 0; sent = 0; tf = '{0, 0};
      in_valid = 1; in_instr = 32'hFFF00093; in_order = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (out_valid && out_first && nf < 2) begin tf[nf] = cyc; nf++; end
         hs = in_valid && in_ready;
         @(posedge clock); #1;
         if (hs) begin
            sent++;
            if (sent == 1) in_instr = 32'h123452B7; else in_valid = 0;
         end
      end
      chk("b2b_firsts", 64'(nf), 2);
      chk("b2b_gap", 64'(tf[1] - tf[0]), 64'(NP));

      // Stall every other cycle: eight beats take sixteen cycles.
      in_valid = 1; in_instr = 32'h0030D093; in_order = 1;
      @(posedge clock); #1 in_valid = 0; out_ready = 0;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (out_valid) cnt++;
         @(posedge clock); #1 out_ready = !out_ready;
      end
      chk("stall_cycles", 64'(cnt), 16);
      out_ready = 1;
      @(posedge clock); #1;

      // Reset during beat 4, with in_valid asserted while reset is held.
      in_valid = 1; in_instr = 32'hFFF00093; in_order = 0;
      @(posedge clock); #1 in_valid = 0;
      repeat (4) @(posedge clock);
      #1 chk("pre_rst_seq", 64'(out_seq), 4);
      reset = 1; in_valid = 1;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 0);
      chk("mid_rst_in_ready", 64'(in_ready), 1);
      chk("mid_rst_seq", 64'(out_seq), 0);
      @(posedge clock); #1;
      @(posedge clock); #1 reset = 0; in_valid = 0;
      chk("post_rst_valid", 64'(out_valid), 0);
      in_valid = 1; in_instr = 32'h123452B7;
      @(posedge clock); #1 in_valid = 0;
      chk("post_rst_first_valid", 64'(out_valid), 1);
      chk("post_rst_first_seq", 64'(out_seq), 0);
      repeat (10) @(posedge clock);
      #1;

`ifdef CLARVI_SEQ_FLUSH_EN
      in_valid = 1; in_instr = 32'hFFF00093;
      @(posedge clock); #1 in_valid = 0;
      @(posedge clock); #1 flush = 1; in_valid = 1;
      chk("flush_in_ready", 64'(in_ready), 0);
      @(posedge clock); #1 flush = 0; in_valid = 0;
      chk("flush_valid", 64'(out_valid), 0);
      @(posedge clock); #1;
`endif

      // Random traffic against the model.
      for (int c = 0; c < 800; c++) begin
         r = $urandom;
         r[6:0] = opcs[$urandom_range(0, 11)];
         in_valid  = ($urandom_range(0, 2) != 0);
         in_instr  = r;
         in_order  = 2'($urandom_range(0, 3));
         in_pc     = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clock); #1;
      end
      in_valid = 0; out_ready = 1;
      repeat (12) @(posedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
